// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN selects alternating arbitration.
package mem_arb_pkg;
    localparam int ADDR_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } owner_e;
endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner selection between the fetch and load/store requesters.
// MEM_ARB_ROUND_ROBIN_EN: on conflict, grant the side that did not win last.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   i_inst_req,
    input  logic   i_data_req,
    input  owner_e i_last_owner,
    output owner_e o_winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        if (i_inst_req && i_data_req) begin
            o_winner = (i_last_owner == DATA) ? INST : DATA;
        end else if (i_data_req) begin
            o_winner = DATA;
        end else begin
            o_winner = INST;
        end
    end
`else
    logic w_unused_last_owner;
    assign w_unused_last_owner = i_last_owner;

    always_comb begin
        if (i_data_req) begin
            o_winner = DATA;
        end else if (i_inst_req) begin
            o_winner = INST;
        end else begin
            o_winner = INST;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master to one-slave memory port arbiter, one transaction in flight.
// Build macro MEM_ARB_ROUND_ROBIN_EN enables alternating conflict resolution.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [31:0]       mem_rdata
);

    state_e      r_state;
    owner_e      r_owner;
    owner_e      w_winner;
    owner_e      w_sel;
    logic        w_sel_req;
    logic        w_fwd;
    logic        w_accept;
    logic        w_done;
    logic [31:0] r_inst_rdata;
    logic [31:0] r_data_rdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e r_last_owner;

    arb_pick u_arb_pick (
        .i_inst_req   (inst_req),
        .i_data_req   (data_req),
        .i_last_owner (r_last_owner),
        .o_winner     (w_winner)
    );
`else
    arb_pick u_arb_pick (
        .i_inst_req   (inst_req),
        .i_data_req   (data_req),
        .i_last_owner (INST),
        .o_winner     (w_winner)
    );
`endif

    // Arbitration is live only in IDLE; afterwards the locked owner alone drives the port.
    always_comb begin
        w_sel     = (r_state == IDLE) ? w_winner : r_owner;
        w_sel_req = 1'b0;
        case (r_state)
            IDLE:    w_sel_req = inst_req || data_req;
            ADDR:    w_sel_req = (r_owner == DATA) ? data_req : inst_req;
            default: w_sel_req = 1'b0;
        endcase
    end

    assign w_fwd = resetn && w_sel_req;

    always_comb begin
        mem_req   = w_fwd;
        mem_wr    = 1'b0;
        mem_wstrb = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (w_fwd) begin
            if (w_sel == DATA) begin
                mem_wr    = data_wr;
                mem_wstrb = data_wstrb;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_addr  = inst_addr;
            end
        end
    end

    assign w_accept     = w_fwd && mem_addr_ok;
    assign w_done       = resetn && (r_state == WAIT) && mem_data_ok;
    assign inst_addr_ok = w_accept && (w_sel == INST);
    assign data_addr_ok = w_accept && (w_sel == DATA);
    assign inst_data_ok = w_done && (r_owner == INST);
    assign data_data_ok = w_done && (r_owner == DATA);
    // Return data is passed through on the completion cycle and held afterwards.
    assign inst_rdata   = inst_data_ok ? mem_rdata : r_inst_rdata;
    assign data_rdata   = data_data_ok ? mem_rdata : r_data_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_owner      <= INST;
            r_inst_rdata <= 32'h0;
            r_data_rdata <= 32'h0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_owner <= INST;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sel_req) begin
                        r_owner <= w_winner;
                        r_state <= mem_addr_ok ? WAIT : ADDR;
                    end
                end
                ADDR: begin
                    if (!w_sel_req) begin
                        r_state <= IDLE;
                    end else if (mem_addr_ok) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_data_ok) begin
                        r_state <= IDLE;
                        if (r_owner == DATA) begin
                            r_data_rdata <= mem_rdata;
                        end else begin
                            r_inst_rdata <= mem_rdata;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (w_accept) begin
                r_last_owner <= w_sel;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; expectations follow the
// MEM_ARB_ROUND_ROBIN_EN setting of the build.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              resetn;
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [31:0]       inst_rdata;
    logic              data_req;
    logic              data_wr;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;
    logic              mem_req;
    logic              mem_wr;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [31:0]       mem_rdata;

    int vectors;
    int miscompares;

    mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        inst_req    = 1'b0;
        inst_addr   = '0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_wstrb  = 4'h0;
        data_addr   = '0;
        data_wdata  = 32'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    logic rr;

    initial begin
        vectors     = 0;
        miscompares = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        resetn = 1'b0;
        clear_inputs();
        inst_req  = 1'b1;
        inst_addr = 32'h1c000000;
        settle();
        chk1 ("rst_mem_req",      mem_req,      1'b0);
        chk32("rst_mem_addr",     mem_addr,     32'h0);
        chk1 ("rst_inst_addr_ok", inst_addr_ok, 1'b0);
        chk32("rst_inst_rdata",   inst_rdata,   32'h0);
        chk32("rst_data_rdata",   data_rdata,   32'h0);
        tick();
        tick();
        clear_inputs();
        resetn = 1'b1;
        tick();

        // Fetch: accept on cycle 0, return on cycle 2
        inst_req = 1'b1; inst_addr = 32'h1c000000; mem_addr_ok = 1'b1;
        settle();
        chk1 ("f_mem_req",      mem_req,      1'b1);
        chk32("f_mem_addr",     mem_addr,     32'h1c000000);
        chk1 ("f_mem_wr",       mem_wr,       1'b0);
        chk1 ("f_inst_addr_ok", inst_addr_ok, 1'b1);
        chk1 ("f_data_addr_ok", data_addr_ok, 1'b0);
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        settle();
        chk1 ("f_wait_mem_req", mem_req,      1'b0);
        chk1 ("f_wait_dok",     inst_data_ok, 1'b0);
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h02800413;
        settle();
        chk1 ("f_inst_data_ok", inst_data_ok, 1'b1);
        chk32("f_inst_rdata",   inst_rdata,   32'h02800413);
        chk1 ("f_data_data_ok", data_data_ok, 1'b0);
        tick();
        mem_data_ok = 1'b0; mem_rdata = 32'h0;
        settle();
        chk1 ("f_dok_pulse",    inst_data_ok, 1'b0);
        chk32("f_rdata_hold",   inst_rdata,   32'h02800413);
        chk32("f_data_rdata",   data_rdata,   32'h0);

        // Stray mem_data_ok while idle
        mem_data_ok = 1'b1; mem_rdata = 32'h55555555;
        settle();
        chk1 ("stray_inst_dok", inst_data_ok, 1'b0);
        chk1 ("stray_data_dok", data_data_ok, 1'b0);
        tick();
        clear_inputs();

        // Conflict: store wins first
        inst_req = 1'b1; inst_addr = 32'h1c000004;
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h100;
        data_wstrb = 4'hF; data_wdata = 32'hDEADBEEF; mem_addr_ok = 1'b1;
        settle();
        chk1 ("c1_mem_wr",       mem_wr,       1'b1);
        chk32("c1_mem_addr",     mem_addr,     32'h100);
        chk32("c1_mem_wdata",    mem_wdata,    32'hDEADBEEF);
        chk32("c1_mem_wstrb",    {28'h0, mem_wstrb}, 32'hF);
        chk1 ("c1_data_addr_ok", data_addr_ok, 1'b1);
        chk1 ("c1_inst_addr_ok", inst_addr_ok, 1'b0);
        tick();
        data_req = 1'b0; mem_addr_ok = 1'b0;
        settle();
        chk1 ("c1_wait_req",     mem_req,      1'b0);
        chk1 ("c1_wait_iaok",    inst_addr_ok, 1'b0);
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h11111111;
        settle();
        chk1 ("c1_data_data_ok", data_data_ok, 1'b1);
        chk1 ("c1_inst_data_ok", inst_data_ok, 1'b0);
        chk32("c1_data_rdata",   data_rdata,   32'h11111111);
        tick();
        // Second conflict in the IDLE cycle following the store completion
        mem_data_ok = 1'b0; mem_rdata = 32'h0;
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h104;
        data_wstrb = 4'h3; data_wdata = 32'hCAFEF00D; mem_addr_ok = 1'b1;
        settle();
        chk32("c2_mem_addr",     mem_addr,     rr ? 32'h1c000004 : 32'h104);
        chk1 ("c2_mem_wr",       mem_wr,       rr ? 1'b0 : 1'b1);
        chk32("c2_mem_wdata",    mem_wdata,    rr ? 32'h0 : 32'hCAFEF00D);
        chk1 ("c2_inst_addr_ok", inst_addr_ok, rr);
        chk1 ("c2_data_addr_ok", data_addr_ok, !rr);
        chk32("c2_data_rdata",   data_rdata,   32'h11111111);
        tick();
        inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'h33333333;
        settle();
        chk1 ("c2_inst_data_ok", inst_data_ok, rr);
        chk1 ("c2_data_data_ok", data_data_ok, !rr);
        chk32("c2_rdata",        rr ? inst_rdata : data_rdata, 32'h33333333);
        tick();
        clear_inputs();
        tick();

        // Fetch locked in ADDR while a load shows up and mem_addr_ok stays low
        inst_req = 1'b1; inst_addr = 32'h1c000008;
        settle();
        chk1 ("a_mem_req",       mem_req,      1'b1);
        chk1 ("a_inst_addr_ok",  inst_addr_ok, 1'b0);
        tick();
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h200;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk32("a_hold_addr",  mem_addr,     32'h1c000008);
            chk1 ("a_hold_daok",  data_addr_ok, 1'b0);
            tick();
        end
        mem_addr_ok = 1'b1;
        settle();
        chk32("a_acc_addr",      mem_addr,     32'h1c000008);
        chk1 ("a_acc_iaok",      inst_addr_ok, 1'b1);
        chk1 ("a_acc_daok",      data_addr_ok, 1'b0);
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0;
        settle();
        chk1 ("a_wait_req",      mem_req,      1'b0);

        // Reset in WAIT abandons the fetch
        resetn = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h44444444;
        settle();
        chk1 ("r_inst_dok",      inst_data_ok, 1'b0);
        chk1 ("r_data_dok",      data_data_ok, 1'b0);
        chk1 ("r_mem_req",       mem_req,      1'b0);
        chk32("r_mem_addr",      mem_addr,     32'h0);
        chk32("r_inst_rdata",    inst_rdata,   32'h0);
        chk32("r_data_rdata",    data_rdata,   32'h0);
        tick();
        data_req = 1'b0;
        resetn = 1'b1;
        settle();
        chk1 ("r_post_idok",     inst_data_ok, 1'b0);
        chk1 ("r_post_ddok",     data_data_ok, 1'b0);
        tick();
        mem_data_ok = 1'b0; mem_rdata = 32'h0;
        data_req = 1'b1; data_addr = 32'h208; mem_addr_ok = 1'b1;
        settle();
        chk1 ("r_idle_daok",     data_addr_ok, 1'b1);
        chk32("r_idle_addr",     mem_addr,     32'h208);
        tick();
        data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h66666666;
        settle();
        chk1 ("r_ld_ddok",       data_data_ok, 1'b1);
        chk32("r_ld_rdata",      data_rdata,   32'h66666666);
        tick();
        clear_inputs();
        tick();

        // Owner withdraws in ADDR
        data_req = 1'b1; data_addr = 32'h300;
        settle();
        chk1 ("w_mem_req",       mem_req,      1'b1);
        tick();
        data_req = 1'b0; mem_addr_ok = 1'b1;
        settle();
        chk1 ("w_drop_req",      mem_req,      1'b0);
        chk1 ("w_drop_daok",     data_addr_ok, 1'b0);
        tick();
        inst_req = 1'b1; inst_addr = 32'h1c00000c;
        settle();
        chk1 ("w_idle_iaok",     inst_addr_ok, 1'b1);
        chk32("w_idle_addr",     mem_addr,     32'h1c00000c);
        tick();
        inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h77777777;
        settle();
        chk1 ("w_idok",          inst_data_ok, 1'b1);
        chk32("w_irdata",        inst_rdata,   32'h77777777);
        tick();
        clear_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
